// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions: FSM state encoding, line levels and nbits decode.
// PARITY exists only when RS232_TX_PARITY_EN is defined.
package rs232_pkg;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic LINE_STOP = 1'b1;
   localparam logic LINE_START = 1'b0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef RS232_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } rs232_state_e;

   // Index of the last data bit; out-of-range requests fall back to 8 bits.
   function automatic logic [2:0] last_bit_idx(input logic [3:0] nbits);
      if (nbits >= 4'd5 && nbits <= 4'd8) begin
         last_bit_idx = 3'(nbits - 4'd1);
      end else begin
         last_bit_idx = 3'd7;
      end
   endfunction

endpackage

// File: rtl/rs232_baud_tick.sv
// Bit-period counter: counts 0..BIT_DIV-1 and pulses tick on the final count.
// A synchronous clear holds the count at 0.
module rs232_baud_tick #(
   parameter int BIT_DIV = 434
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = $clog2(BIT_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else if (clr || cnt == CNT_MAX) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/rs232_tx.sv
// RS-232 transmitter: start, 5..8 data bits LSB first, optional even parity
// (macro RS232_TX_PARITY_EN), one stop bit.
module rs232_tx
   import rs232_pkg::*;
#(
   parameter int BIT_DIV = 434,
   parameter int DATA_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [3:0]        nbits_i,
   output logic              tx_o,
   output logic              busy_o,
   output logic              eot_o,
   output logic              done_o,
   output logic [2:0]        state_o
);

   rs232_state_e      state_q, state_d;
   logic              tx_q, tx_d;
   logic [DATA_W-1:0] shreg;
   logic [2:0]        bit_cnt;
   logic [2:0]        last_idx;
   logic              tick;
   logic              accept;
   logic              last_bit;
`ifdef RS232_TX_PARITY_EN
   logic              par_q;
`endif

   // Counter is held clear throughout IDLE, so it starts from 0 in START.
   rs232_baud_tick #(
      .BIT_DIV (BIT_DIV)
   ) u_tick (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr   (state_q == IDLE),
      .tick  (tick)
   );

   assign accept   = (state_q == IDLE) && start_i;
   assign last_bit = (bit_cnt == last_idx);

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      done_o  = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = LINE_IDLE;
            if (start_i) begin
               state_d = START;
               tx_d    = LINE_START;
            end
         end
         START: begin
            if (tick) begin
               state_d = DATA;
               tx_d    = shreg[0];
            end
         end
         DATA: begin
            if (tick) begin
               if (last_bit) begin
`ifdef RS232_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = par_q ^ shreg[0];
`else
                  state_d = STOP;
                  tx_d    = LINE_STOP;
`endif
               end else begin
                  tx_d = shreg[1];
               end
            end
         end
`ifdef RS232_TX_PARITY_EN
         PARITY: begin
            if (tick) begin
               state_d = STOP;
               tx_d    = LINE_STOP;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               state_d = IDLE;
               tx_d    = LINE_IDLE;
               done_o  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = LINE_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         tx_q    <= LINE_IDLE;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         last_idx <= '0;
      end else if (accept) begin
         shreg    <= data_i;
         bit_cnt  <= '0;
         last_idx <= last_bit_idx(nbits_i);
      end else if (state_q == DATA && tick) begin
         shreg    <= shreg >> 1;
         bit_cnt  <= bit_cnt + 3'd1;
      end
   end

`ifdef RS232_TX_PARITY_EN
   // Running XOR of the bits already shifted out; the last bit is folded in at decode.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         par_q <= 1'b0;
      end else if (accept) begin
         par_q <= 1'b0;
      end else if (state_q == DATA && tick) begin
         par_q <= par_q ^ shreg[0];
      end
   end
`endif

   assign tx_o    = tx_q;
   assign eot_o   = (state_q == IDLE);
   assign busy_o  = !eot_o;
   assign state_o = state_q;

endmodule

// File: tb/tb_rs232_tx.sv
// Scoreboard bench for rs232_tx: driver pushes expected frames, a line monitor
// decodes tx_o cycle by cycle and compares against a frame model.
module tb_rs232_tx;

   localparam int BIT_DIV = 4;
   localparam int W = 12;
`ifdef RS232_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       start_i = 1'b0;
   logic [7:0] data_i = 8'h00;
   logic [3:0] nbits_i = 4'd8;
   logic       tx_o, busy_o, eot_o, done_o;
   logic [2:0] state_o;

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int frames_pushed = 0;
   int frames_seen = 0;
   bit mon_en = 1'b1;

   rs232_tx #(.BIT_DIV(BIT_DIV), .DATA_W(8)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i),
      .data_i  (data_i),
      .nbits_i (nbits_i),
      .tx_o    (tx_o),
      .busy_o  (busy_o),
      .eot_o   (eot_o),
      .done_o  (done_o),
      .state_o (state_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
      end
   endtask

   // Frame model: effective bit count and the expected line bit sequence.
   function automatic int eff_n(input logic [3:0] n);
      return (n >= 5 && n <= 8) ? int'(n) : 8;
   endfunction

   function automatic logic [11:0] frame_bits(input logic [7:0] d, input logic [3:0] n);
      logic [11:0] v;
      int ne;
      int ones;
      ne = eff_n(n);
      v = '0;
      ones = 0;
      v[0] = 1'b0;
      for (int i = 0; i < ne; i++) begin
         v[1+i] = d[i];
         ones += int'(d[i]);
      end
      if (P == 1) v[1+ne] = logic'(ones % 2);
      v[ne+P+1] = 1'b1;
      return v;
   endfunction

   // Monitor
   task automatic watch_frame();
      logic [W-1:0] ent;
      logic [11:0] expv, obs;
      int len, stable_err, done_err, busy_err;
      if (exp_q.size() == 0) begin
         check("unexpected_frame", 1, 0);
         for (int k = 0; k < 200 && !eot_o; k++) @(negedge clk_i);
         return;
      end
      ent = exp_q.pop_front();
      frames_seen++;
      expv = frame_bits(ent[7:0], ent[11:8]);
      len = eff_n(ent[11:8]) + P + 2;
      obs = '0;
      stable_err = 0;
      done_err = 0;
      busy_err = 0;
      for (int b = 0; b < len; b++) begin
         for (int c = 0; c < BIT_DIV; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk_i);
            if (c == 0) obs[b] = tx_o;
            if (tx_o !== expv[b]) stable_err++;
            if (done_o !== ((b == len - 1) && (c == BIT_DIV - 1))) done_err++;
            if (busy_o !== 1'b1 || eot_o !== 1'b0) busy_err++;
         end
      end
      check("frame_bits", int'(obs), int'(expv));
      check("bit_hold", stable_err, 0);
      check("done_pulse", done_err, 0);
      check("busy_during_frame", busy_err, 0);
      @(negedge clk_i);
      check("idle_after_frame", int'({eot_o, tx_o}), 3);
   endtask

   initial begin
      logic tx_prev;
      tx_prev = 1'b1;
      forever begin
         @(negedge clk_i);
         if (mon_en && !rst_i && tx_prev && !tx_o) watch_frame();
         tx_prev = tx_o;
      end
   end

   // Driver
   task automatic wait_idle();
      int k;
      k = 0;
      do begin
         @(negedge clk_i);
         k++;
      end while (!(eot_o && exp_q.size() == 0) && k < 2000);
      if (k >= 2000) check("idle_timeout", 1, 0);
   endtask

   task automatic send(input logic [7:0] d, input logic [3:0] n, input bit push);
      wait_idle();
      start_i = 1'b1;
      data_i = d;
      nbits_i = n;
      if (push) begin
         exp_q.push_back({n, d});
         frames_pushed++;
      end
      @(negedge clk_i);
      start_i = 1'b0;
      data_i = 8'($urandom);
      nbits_i = 4'($urandom);
   endtask

   // Measures accept-to-done and accept-to-idle distances of the frame just sent.
   task automatic measure(input string name, input int len_bits);
      int k;
      k = 1;
      while (!done_o && k < 400) begin
         @(negedge clk_i);
         k++;
      end
      check({name, "_done_cycle"}, k, len_bits * BIT_DIV);
      @(negedge clk_i);
      check({name, "_eot_cycle"}, int'(eot_o), 1);
   endtask

   initial begin
      repeat (3) @(negedge clk_i);
      check("rst_tx", int'(tx_o), 1);
      check("rst_busy", int'(busy_o), 0);
      check("rst_eot", int'(eot_o), 1);
      check("rst_done", int'(done_o), 0);
      rst_i = 1'b0;

      send(8'hA5, 4'd8, 1'b1);
      measure("a5_n8", 10 + P);

      send(8'h03, 4'd7, 1'b1);
      measure("03_n7", 9 + P);

      send(8'h3C, 4'd12, 1'b1);
      send(8'h81, 4'd0, 1'b1);
      send(8'h1F, 4'd5, 1'b1);

      // start_i held through a frame while data_i changes mid-frame
      wait_idle();
      start_i = 1'b1;
      data_i = 8'h55;
      nbits_i = 4'd8;
      exp_q.push_back({4'd8, 8'h55});
      frames_pushed++;
      repeat (20) @(negedge clk_i);
      data_i = 8'hFF;
      exp_q.push_back({4'd8, 8'hFF});
      frames_pushed++;
      begin
         int k;
         k = 0;
         while (!done_o && k < 400) begin
            @(negedge clk_i);
            k++;
         end
      end
      @(negedge clk_i);
      check("rearm_idle", int'(eot_o), 1);
      @(negedge clk_i);
      check("rearm_accept", int'(busy_o), 1);
      start_i = 1'b0;

      // reset inside the third data bit
      wait_idle();
      mon_en = 1'b0;
      start_i = 1'b1;
      data_i = 8'($urandom);
      nbits_i = 4'd8;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (13) @(negedge clk_i);
      check("pre_rst_busy", int'(busy_o), 1);
      rst_i = 1'b1;
      #1;
      check("midrst_tx", int'(tx_o), 1);
      check("midrst_busy", int'(busy_o), 0);
      check("midrst_eot", int'(eot_o), 1);
      check("midrst_done", int'(done_o), 0);
      @(negedge clk_i);
      check("midrst_done_held", int'(done_o), 0);
      start_i = 1'b1;
      data_i = 8'hC6;
      nbits_i = 4'd8;
      exp_q.push_back({4'd8, 8'hC6});
      frames_pushed++;
      mon_en = 1'b1;
      rst_i = 1'b0;
      @(negedge clk_i);
      start_i = 1'b0;
      check("post_rst_accept", int'(busy_o), 1);

      // loopback of random bytes, then random bit counts
      for (int i = 0; i < 256; i++) begin
         send(8'($urandom), 4'd8, 1'b1);
         repeat ($urandom_range(0, 3)) @(negedge clk_i);
      end
      for (int i = 0; i < 24; i++) begin
         send(8'($urandom), 4'($urandom_range(0, 15)), 1'b1);
      end

      wait_idle();
      repeat (4) @(negedge clk_i);
      check("queue_drained", exp_q.size(), 0);
      check("frames_seen", frames_seen, frames_pushed);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rs232_tx.md
RS232_TX -- requirements
Module: rs232_tx

Interface
REQ-001 SHALL have parameter BIT_DIV, default 434, clk_i cycles per serial bit (legal 2..65535).
REQ-002 SHALL have parameter DATA_W, default 8, width of data_i.
REQ-003 SHALL have port clk_i  input  1  rising-edge clock.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start_i  input  1  request to send one frame, sampled only in IDLE.
REQ-006 SHALL have port data_i  input  DATA_W  frame payload, captured when start_i is accepted.
REQ-007 SHALL have port nbits_i  input  4  data-bit count (5..8), captured when start_i is accepted.
REQ-008 SHALL have port tx_o  output  1  serial line; idle and stop level is 1.
REQ-009 SHALL have port busy_o  output  1  high from the accept cycle until the frame ends.
REQ-010 SHALL have port eot_o  output  1  end-of-transmission level, high exactly when the FSM is in IDLE.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse in the last cycle of the stop bit.

Function
REQ-012 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-013 SHALL accept start_i only in IDLE; the next cycle enters START with tx_o=0, and the bit-tick counter is cleared.
REQ-014 SHALL hold every bit (start, each data bit, parity, stop) on tx_o for exactly BIT_DIV clk_i cycles.
REQ-015 SHALL shift data LSB first from a register loaded at accept; later data_i changes do not affect the frame in flight.
REQ-016 SHALL send nbits_i data bits; latched values 0..4 or 9..15 are treated as 8.
REQ-017 SHALL use a bit counter that runs from 0 and leaves DATA when the count equals nbits-1 at the end-of-bit tick.
REQ-018 SHALL, after DATA, go to PARITY (REQ-029) or STOP, drive tx_o=1 for one bit period in STOP, pulse done_o in its last cycle, then return to IDLE.
REQ-019 SHALL give a frame length of (1+nbits+P+1)*BIT_DIV cycles, where P=1 with parity and 0 without; start_i is accepted again in the first IDLE cycle.
REQ-020 SHALL ignore start_i while busy_o=1, with no queuing.
REQ-021 SHALL register tx_o, so that it is glitch-free.
REQ-022 SHALL derive busy_o and eot_o from the state (busy_o = !eot_o).

Reset
REQ-023 SHALL, while rst_i=1, force the state to IDLE and set tx_o=1, busy_o=0, eot_o=1, done_o=0 asynchronously.
REQ-024 SHALL clear the shift register, bit counter and tick counter to 0 on reset.
REQ-025 SHALL, on reset mid-frame, abort the frame immediately with the line at 1 and no done_o pulse.
REQ-026 SHALL, on the first clock after rst_i falls with start_i=1, accept the request normally.

Configuration
REQ-027 SHALL use macro RS232_TX_PARITY_EN to compile parity support in or out.
REQ-028 SHALL, when RS232_TX_PARITY_EN is undefined, contain no PARITY state or parity logic, giving a frame of start + nbits + stop.
REQ-029 SHALL, when RS232_TX_PARITY_EN is defined, send one even-parity bit (XOR of the nbits sent data bits) between DATA and STOP.

Structure
REQ-030 SHALL place the state encoding constants (3-bit IDLE=0 .. STOP=4) and the IDLE/stop line level in shared package rs232_pkg, which rs232_rx users also import.
REQ-031 SHALL use one sub-module, rs232_baud_tick, containing the counter from 0 to BIT_DIV-1, with a synchronous clear input and a one-cycle tick output.
REQ-032 SHALL keep FSM next-state and output decode in rs232_tx itself.

Verification
REQ-033 SHALL cover: BIT_DIV=4, nbits_i=8, data_i=8'hA5, parity off -> tx_o is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; done_o pulses at cycle 40; eot_o returns high at cycle 41.
REQ-034 SHALL cover: parity on, nbits_i=7, data_i=8'h03 -> 7 data bits 1,1,0,0,0,0,0 then parity 0 then stop; frame is 40 cycles.
REQ-035 SHALL cover: start_i held high through a frame of 8'h55 with data_i changed to 8'hFF mid-frame -> exactly one 8'h55 frame, a new frame accepted in the first IDLE cycle, and no double start.
REQ-036 SHALL cover: rst_i asserted in the 3rd data bit -> tx_o=1, busy_o=0, eot_o=1 within the same cycle, and no done_o.
REQ-037 SHALL cover: nbits_i=4'd12 -> 8 data bits sent.
REQ-038 SHALL cover: loopback into rs232_rx with BIT_DIV=434 and 256 random bytes -> all bytes received equal to those sent.
